display_scan_controller: RTL and testbench
==========================================

Name: display_scan_controller

Overview:
Upstream feeder for the 4-digit seven-segment decoder. Holds a 4-digit BCD value in a shadow register and time-multiplexes it: one digit per refresh slot, driving the decoder's number[3:0] and display_select[1:0] inputs. New values are accepted through a load strobe and take effect only at a frame boundary, so no frame is ever torn. Optional leading-zero blanking outputs the blank code 4'hF; the decoder's default branch turns all segments off for that code.

Parameters:
REFRESH_DIV, 50000, clk cycles per digit slot; legal range >= 1; sim benches use 4.
NUM_DIGITS, 4, digits scanned; fixed at 4 to match the 2-bit display_select.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
value_bcd  input  16  four BCD digits; [3:0] is digit 0 (least significant), [15:12] is digit 3
load  input  1  single-cycle strobe; captures value_bcd
blank_lz  input  1  1 = blank leading zeros on digits 3..1
number  output  4  digit code to the decoder; 4'hF = blank
display_select  output  2  active digit index to the decoder
frame_done  output  1  1-cycle pulse when a full 4-digit frame completes
load_ack  output  1  1-cycle pulse when a pending load is committed to the shadow register

Behaviour:
- Reset (async assert, sync release):
  - Prescaler = 0, digit index = 0, shadow = 16'h0000, pending flag = 0, pending value = 0.
  - Outputs: number = 4'hF, display_select = 2'b00, frame_done = 0, load_ack = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick is asserted in the cycle the count equals REFRESH_DIV-1.
  - With REFRESH_DIV = 1, tick is asserted every cycle.
- Digit index:
  - Advances on tick: 0->1->2->3->0.
  - A frame boundary is a tick while the index = 3.
- Outputs:
  - number and display_select are registered.
  - They reflect the current index and shadow one cycle after the index changes; this one-cycle latency is allowed.
  - display_select = index.
  - number = shadow digit[index], or 4'hF when that digit is blanked.
- Leading-zero blanking (blank_lz = 1):
  - Digit k (k = 3,2,1) is blanked iff shadow digits k..3 are all 0.
  - Digit 0 is never blanked, so shadow 0000 displays "0".
  - blank_lz is sampled every cycle; no latching.
- Non-BCD digits (A..F) pass through unchanged; the decoder blanks them.
- Load handshake:
  - load = 1: pending value <= value_bcd, pending flag <= 1.
  - A later load before commit overwrites the pending value. Last value wins; no ack is issued for the overwritten value.
- Commit at a frame boundary:
  - If pending = 1: shadow <= pending value, pending <= 0.
  - load_ack pulses in the cycle after the boundary; frame_done pulses in that same cycle.
- Load in the same cycle as a frame boundary: value_bcd bypasses to shadow directly and load_ack is issued. An older pending value is discarded.
- frame_done pulses every frame, whether or not a commit occurs.
- Reset mid-frame: everything returns to reset state immediately, and any pending load is lost (no ack).
- No other state machine exists; index plus the pending flag are the whole control state.

Decomposition:
- Package display_pkg holds:
  - NUM_DIGITS = 4
  - BLANK_CODE = 4'hF
  - the digit-index type (2-bit)
  - a BCD-digit type (4-bit)
- Sub-module refresh_prescaler (parameter DIV; ports clk, rst_n, tick) is natural and reusable by other timing blocks.
- Blanking logic stays inline.

Test Plan:
- Reset, REFRESH_DIV=4, no load -> after reset release, number=4'h0 and display_select 0,1,2,3 repeating, each held 4 cycles; frame_done every 16 cycles.
- load with value_bcd=16'h1234 mid-frame -> display unchanged until the next boundary; load_ack and frame_done pulse together; next frame shows 4,3,2,1 on selects 0..3.
- load 16'h0007 then load 16'h0042 in the same frame -> a single load_ack; the frame shows 2,4,0,0; 0007 is never displayed.
- blank_lz=1, commit 16'h0050 -> selects 0..3 show 0,5,F,F; commit 16'h0000 -> 0,F,F,F.
- load asserted exactly on the boundary cycle with 16'h9876 -> committed in that boundary; the next frame shows 6,7,8,9 and load_ack pulses once.
- rst_n pulsed low mid-frame with a pending load -> outputs return to reset values asynchronously; no load_ack follows; the display shows shadow 0000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan path.
package display_pkg;
   localparam int NUM_DIGITS = 4;
   localparam logic [3:0] BLANK_CODE = 4'hF;

   typedef logic [1:0] digit_idx_t;
   typedef logic [3:0] bcd_digit_t;

   function automatic bcd_digit_t get_digit(input logic [15:0] value, input digit_idx_t idx);
      return value[{idx, 2'b00} +: 4];
   endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider: tick is high for one cycle out of every DIV cycles.
module refresh_prescaler #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   // A 1-bit counter keeps DIV = 1 legal; it then never leaves zero.
   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_reg;

   assign tick = (cnt_reg == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_reg <= '0;
      else if (tick)
         cnt_reg <= '0;
      else
         cnt_reg <= cnt_reg + 1'b1;
   end
endmodule

// File: rtl/display_scan_controller.sv
// Multiplexes a 4-digit BCD shadow register onto the seven-segment decoder,
// committing new values only at frame boundaries so a frame is never torn.
module display_scan_controller
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value_bcd,
   input  logic        load,
   input  logic        blank_lz,
   output logic [3:0]  number,
   output logic [1:0]  display_select,
   output logic        frame_done,
   output logic        load_ack
);
   logic        tick;
   logic        boundary;

   digit_idx_t  idx_reg, idx_next;
   logic [15:0] shadow_reg, shadow_next;
   logic        pend_reg, pend_next;
   logic [15:0] pval_reg, pval_next;

   bcd_digit_t  number_reg, number_next;
   digit_idx_t  sel_reg;
   logic        frame_done_reg, frame_done_next;
   logic        load_ack_reg, load_ack_next;

   logic [NUM_DIGITS-1:1] lz;
   logic [NUM_DIGITS-1:0] blank_mask;

   refresh_prescaler #(.DIV(REFRESH_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign boundary = tick && (idx_reg == digit_idx_t'(NUM_DIGITS - 1));

   // lz[k]: shadow digits k..3 are all zero; digit 0 always shows.
   assign lz[NUM_DIGITS-1]         = (shadow_reg[15:12] == 4'h0);
   assign blank_mask[0]            = 1'b0;
   assign blank_mask[NUM_DIGITS-1] = blank_lz && lz[NUM_DIGITS-1];

   genvar gi;
   generate
      for (gi = 1; gi < NUM_DIGITS - 1; gi++) begin : g_lz
         assign lz[gi]         = lz[gi+1] && (shadow_reg[4*gi +: 4] == 4'h0);
         assign blank_mask[gi] = blank_lz && lz[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg        <= '0;
         shadow_reg     <= '0;
         pend_reg       <= 1'b0;
         pval_reg       <= '0;
         number_reg     <= BLANK_CODE;
         sel_reg        <= '0;
         frame_done_reg <= 1'b0;
         load_ack_reg   <= 1'b0;
      end else begin
         idx_reg        <= idx_next;
         shadow_reg     <= shadow_next;
         pend_reg       <= pend_next;
         pval_reg       <= pval_next;
         number_reg     <= number_next;
         sel_reg        <= idx_reg;
         frame_done_reg <= frame_done_next;
         load_ack_reg   <= load_ack_next;
      end
   end

   // A load coinciding with the boundary bypasses the pending slot entirely.
   always_comb begin
      idx_next        = tick ? idx_reg + 2'd1 : idx_reg;
      shadow_next     = shadow_reg;
      pend_next       = pend_reg;
      pval_next       = pval_reg;
      load_ack_next   = 1'b0;
      frame_done_next = boundary;
      if (boundary) begin
         if (load) begin
            shadow_next   = value_bcd;
            pend_next     = 1'b0;
            load_ack_next = 1'b1;
         end else if (pend_reg) begin
            shadow_next   = pval_reg;
            pend_next     = 1'b0;
            load_ack_next = 1'b1;
         end
      end else if (load) begin
         pend_next = 1'b1;
         pval_next = value_bcd;
      end
   end

   always_comb begin
      number_next = blank_mask[idx_reg] ? BLANK_CODE : get_digit(shadow_reg, idx_reg);
   end

   assign number         = number_reg;
   assign display_select = sel_reg;
   assign frame_done     = frame_done_reg;
   assign load_ack       = load_ack_reg;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a 4-cycle refresh slot.
module tb_display_scan_controller;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] value_bcd = '0;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  number;
   logic [1:0]  display_select;
   logic        frame_done;
   logic        load_ack;

   int checks = 0;
   int errors = 0;

   display_scan_controller #(.REFRESH_DIV(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .value_bcd      (value_bcd),
      .load           (load),
      .blank_lz       (blank_lz),
      .number         (number),
      .display_select (display_select),
      .frame_done     (frame_done),
      .load_ack       (load_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_load(input logic [15:0] v);
      value_bcd = v;
      load = 1'b1;
      step(1);
      load = 1'b0;
   endtask

   // Advance until frame_done is seen (bounded), then check load_ack alongside it.
   task automatic wait_boundary(input string tag, input logic exp_ack);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (frame_done) begin
            found = 1'b1;
            break;
         end
      end
      chk({tag, "_boundary_seen"}, 16'(found), 16'h1);
      chk({tag, "_ack"}, 16'(load_ack), 16'(exp_ack));
   endtask

   // Called while frame_done is visible; checks the next frame slot by slot.
   task automatic show_frame(input string tag, input logic [15:0] exp_nums);
      logic [15:0] nums;
      nums = exp_nums;
      step(1);
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("%s_sel%0d", tag, j), 16'(display_select), 16'(j));
         chk($sformatf("%s_num%0d", tag, j), 16'(number), 16'(nums[4*j +: 4]));
         chk($sformatf("%s_ack%0d", tag, j), 16'(load_ack), 16'h0);
         step(j < 3 ? 4 : 3);
      end
      chk({tag, "_next_frame_done"}, 16'(frame_done), 16'h1);
      chk({tag, "_next_ack"}, 16'(load_ack), 16'h0);
   endtask

   initial begin
      // Reset state
      step(2);
      chk("rst_number", 16'(number), 16'hF);
      chk("rst_select", 16'(display_select), 16'h0);
      chk("rst_frame_done", 16'(frame_done), 16'h0);
      chk("rst_load_ack", 16'(load_ack), 16'h0);
      rst_n = 1'b1;

      // Free-running scan of shadow 0000: each select held 4 cycles, frame every 16
      for (int n = 1; n <= 32; n++) begin
         step(1);
         chk($sformatf("scan_sel_c%0d", n), 16'(display_select), 16'(((n - 1) / 4) % 4));
         chk($sformatf("scan_num_c%0d", n), 16'(number), 16'h0);
         chk($sformatf("scan_fd_c%0d", n), 16'(frame_done), 16'((n % 16) == 0));
         chk($sformatf("scan_ack_c%0d", n), 16'(load_ack), 16'h0);
      end

      // Mid-frame load of 1234 does not disturb the current frame
      step(6);
      pulse_load(16'h1234);
      for (int n = 0; n < 8; n++) begin
         chk($sformatf("hold_num_%0d", n), 16'(number), 16'h0);
         step(1);
      end
      wait_boundary("load1234", 1'b1);
      show_frame("f1234", 16'h1234);

      // Two loads in one frame: last wins, single ack
      step(2);
      pulse_load(16'h0007);
      step(3);
      pulse_load(16'h0042);
      wait_boundary("load0042", 1'b1);
      show_frame("f0042", 16'h0042);

      // Leading-zero blanking
      blank_lz = 1'b1;
      step(2);
      pulse_load(16'h0050);
      wait_boundary("load0050", 1'b1);
      show_frame("f0050_blank", 16'hFF50);
      step(2);
      pulse_load(16'h0000);
      wait_boundary("load0000", 1'b1);
      show_frame("f0000_blank", 16'hFFF0);
      blank_lz = 1'b0;

      // Load exactly on the boundary cycle overrides an older pending value
      step(3);
      pulse_load(16'h1111);
      step(11);
      pulse_load(16'h9876);
      chk("bypass_frame_done", 16'(frame_done), 16'h1);
      chk("bypass_ack", 16'(load_ack), 16'h1);
      show_frame("f9876", 16'h9876);

      // Asynchronous reset mid-frame drops a pending load
      step(5);
      pulse_load(16'h5555);
      step(2);
      rst_n = 1'b0;
      #1;
      chk("arst_number", 16'(number), 16'hF);
      chk("arst_select", 16'(display_select), 16'h0);
      chk("arst_frame_done", 16'(frame_done), 16'h0);
      chk("arst_ack", 16'(load_ack), 16'h0);
      step(1);
      rst_n = 1'b1;
      wait_boundary("post_rst", 1'b0);
      show_frame("f_post_rst", 16'h0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
